testutil_sigdump: RTL and testbench

//  Parametrised simulation test-utility device for the compliance/bring-up tops. Sits on the bus as a device
//  (register window) and as a host (bus master). On the software exit write, it autonomously reads the

---
 rtl/testutil_pkg.sv | 25 ++
 rtl/testutil_sig_fifo.sv | 57 +++++
 rtl/testutil_sigdump.sv | 235 +++++++++++++++++++++++
 tb/tb_testutil_sigdump.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/testutil_pkg.sv
// Shared register map, STATUS bit positions and dump FSM state type for testutil_sigdump.
package testutil_pkg;

   localparam logic [7:0] OFF_SIG_BEGIN = 8'h00;
   localparam logic [7:0] OFF_SIG_END   = 8'h04;
   localparam logic [7:0] OFF_EXIT      = 8'h08;
   localparam logic [7:0] OFF_STATUS    = 8'h0C;
   localparam logic [7:0] OFF_CONSOLE   = 8'h10;

   localparam int unsigned STATUS_BUSY = 0;
   localparam int unsigned STATUS_DONE = 1;
   localparam int unsigned STATUS_ERR  = 2;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } sigdump_state_e;

   function automatic logic is_busy(input sigdump_state_e s);
      return (s == ISSUE) || (s == DRAIN);
   endfunction

endpackage

// File: rtl/testutil_sig_fifo.sv
// Synchronous FIFO buffering signature words; async active-low reset, data reads 0 when empty.
module testutil_sig_fifo #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [Width-1:0]           wdata,
   input  logic                       pop,
   output logic [Width-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(Depth+1)-1:0] count
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem [Depth];
   logic [PtrW-1:0]  wr_ptr, rd_ptr;
   logic [CntW-1:0]  cnt;
   logic             do_push, do_pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (32'(p) == Depth - 1) ? '0 : p + PtrW'(1);
   endfunction

   assign empty   = (cnt == '0);
   assign full    = (32'(cnt) == Depth);
   assign count   = cnt;
   assign do_pop  = pop && !empty;
   // A push while full is accepted only when the same cycle frees a slot.
   assign do_push = push && (!full || do_pop);
   assign rdata   = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CntW'(1);
            2'b01:   cnt <= cnt - CntW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/testutil_sigdump.sv
// Test-utility device: register window plus a bus host that dumps [SIG_BEGIN, SIG_END) on EXIT.
// Optional macro TESTUTIL_CONSOLE_EN maps a character console at offset 0x10.
module testutil_sigdump
   import testutil_pkg::*;
#(
   parameter int unsigned AddrWidth      = 32,
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned MaxOutstanding = 2,
   parameter int unsigned SigFifoDepth   = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   dev_req_i,
   input  logic                   dev_we_i,
   input  logic [AddrWidth-1:0]   dev_addr_i,
   input  logic [DataWidth-1:0]   dev_wdata_i,
   input  logic [DataWidth/8-1:0] dev_be_i,
   output logic                   dev_rvalid_o,
   output logic [DataWidth-1:0]   dev_rdata_o,
   output logic                   dev_err_o,
   output logic                   host_req_o,
   input  logic                   host_gnt_i,
   output logic [AddrWidth-1:0]   host_addr_o,
   input  logic                   host_rvalid_i,
   input  logic [DataWidth-1:0]   host_rdata_i,
   input  logic                   host_err_i,
   output logic                   sig_valid_o,
   input  logic                   sig_ready_i,
   output logic [DataWidth-1:0]   sig_data_o,
   output logic                   done_o,
   output logic [DataWidth-1:0]   exit_code_o
);

   localparam int unsigned NumBytes = DataWidth / 8;
   localparam int unsigned CntW     = $clog2(SigFifoDepth + 1);
   localparam int unsigned OstW     = $clog2(MaxOutstanding + 1);
   localparam logic [AddrWidth-1:0] AlignMask = ~AddrWidth'(NumBytes - 1);

   sigdump_state_e       state_q, state_d;
   logic [DataWidth-1:0] sig_begin_q, sig_end_q;
   logic [AddrWidth-1:0] sig_begin_a, sig_end_a;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic [AddrWidth:0]   addr_next;
   logic [OstW-1:0]      ost_q;
   logic [CntW-1:0]      fifo_count;
   logic                 fifo_empty, unused_fifo_full;
   logic                 err_q, busy, grant, accept_rsp, can_issue, start;
   logic                 wr_begin, wr_end, wr_exit;
   logic [DataWidth-1:0] rsp_data, status;
   logic                 rsp_err;
   logic [7:0]           offset;
   logic                 unused_addr;

   function automatic logic [DataWidth-1:0] be_merge(
      input logic [DataWidth-1:0] old,
      input logic [DataWidth-1:0] wd,
      input logic [NumBytes-1:0]  be
   );
      logic [DataWidth-1:0] res;
      res = old;
      for (int unsigned i = 0; i < NumBytes; i++) begin
         if (be[i]) res[8*i +: 8] = wd[8*i +: 8];
      end
      return res;
   endfunction

   assign offset      = dev_addr_i[7:0];
   assign unused_addr = ^dev_addr_i[AddrWidth-1:8];
   assign busy        = is_busy(state_q);
   assign sig_begin_a = AddrWidth'(sig_begin_q);
   assign sig_end_a   = AddrWidth'(sig_end_q);

   always_comb begin
      status               = '0;
      status[STATUS_BUSY]  = busy;
      status[STATUS_DONE]  = (state_q == DONE);
      status[STATUS_ERR]   = err_q;
   end

`ifdef TESTUTIL_CONSOLE_EN
   logic        wr_console;
   logic [15:0] console_cnt_q;
`endif

   always_comb begin
      rsp_data = '0;
      rsp_err  = 1'b0;
      wr_begin = 1'b0;
      wr_end   = 1'b0;
      wr_exit  = 1'b0;
`ifdef TESTUTIL_CONSOLE_EN
      wr_console = 1'b0;
`endif
      if (dev_req_i) begin
         case (offset)
            OFF_SIG_BEGIN: begin
               if (!dev_we_i)  rsp_data = sig_begin_q;
               else if (busy)  rsp_err  = 1'b1;
               else            wr_begin = 1'b1;
            end
            OFF_SIG_END: begin
               if (!dev_we_i)  rsp_data = sig_end_q;
               else if (busy)  rsp_err  = 1'b1;
               else            wr_end   = 1'b1;
            end
            OFF_EXIT: begin
               if (dev_we_i) begin
                  if (busy) rsp_err = 1'b1;
                  else      wr_exit = 1'b1;
               end
            end
            OFF_STATUS: begin
               if (!dev_we_i) rsp_data = status;
            end
`ifdef TESTUTIL_CONSOLE_EN
            OFF_CONSOLE: begin
               if (dev_we_i) wr_console = 1'b1;
               else          rsp_data   = DataWidth'(console_cnt_q);
            end
`endif
            default: rsp_err = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dev_rvalid_o <= 1'b0;
         dev_rdata_o  <= '0;
         dev_err_o    <= 1'b0;
         sig_begin_q  <= '0;
         sig_end_q    <= '0;
         exit_code_o  <= '0;
      end else begin
         dev_rvalid_o <= dev_req_i;
         dev_rdata_o  <= rsp_data;
         dev_err_o    <= rsp_err;
         if (wr_begin) sig_begin_q <= be_merge(sig_begin_q, dev_wdata_i, dev_be_i);
         if (wr_end)   sig_end_q   <= be_merge(sig_end_q, dev_wdata_i, dev_be_i);
         if (wr_exit)  exit_code_o <= be_merge(exit_code_o, dev_wdata_i, dev_be_i);
      end
   end

`ifdef TESTUTIL_CONSOLE_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         console_cnt_q <= '0;
      end else if (wr_console && dev_be_i[0]) begin
         $write("%c", dev_wdata_i[7:0]);
         console_cnt_q <= console_cnt_q + 16'd1;
      end
   end
`endif

   // Reserving the FIFO slot at grant time is what keeps the buffer from overflowing.
   assign can_issue  = ((32'(ost_q) + 32'(fifo_count)) < SigFifoDepth) &&
                       (32'(ost_q) < MaxOutstanding);
   assign grant      = host_req_o && host_gnt_i;
   assign accept_rsp = host_rvalid_i && (ost_q != '0);
   assign start      = wr_exit && (state_q == IDLE);
   assign addr_next  = {1'b0, addr_q} + (AddrWidth + 1)'(NumBytes);

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      host_req_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               addr_d  = sig_begin_a & AlignMask;
               state_d = (sig_end_a <= sig_begin_a) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            host_req_o = can_issue;
            if (grant) begin
               addr_d = addr_next[AddrWidth-1:0];
               // Carry out of the address is handled like reaching SIG_END.
               if (addr_next[AddrWidth] || (addr_next[AddrWidth-1:0] >= sig_end_a)) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if ((ost_q == '0) && fifo_empty) state_d = DONE;
         end
         DONE: ;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         addr_q  <= '0;
         ost_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         case ({grant, accept_rsp})
            2'b10:   ost_q <= ost_q + OstW'(1);
            2'b01:   ost_q <= ost_q - OstW'(1);
            default: ;
         endcase
         if (accept_rsp && host_err_i) err_q <= 1'b1;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (rst_ni && host_rvalid_i) begin
         assert (ost_q != '0) else $warning("testutil_sigdump: host response with nothing outstanding dropped");
      end
   end
`endif

   testutil_sig_fifo #(
      .Depth (SigFifoDepth),
      .Width (DataWidth)
   ) u_sig_fifo (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .push  (accept_rsp),
      .wdata (host_rdata_i),
      .pop   (sig_valid_o && sig_ready_i),
      .rdata (sig_data_o),
      .full  (unused_fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign sig_valid_o = !fifo_empty;
   assign done_o      = (state_q == DONE);
   assign host_addr_o = addr_q;

endmodule

// File: tb/tb_testutil_sigdump.sv
// Scoreboard bench for testutil_sigdump: a host memory model returns data == address.
module tb_testutil_sigdump;

   logic        clk;
   logic        rst_n;
   logic        dev_req, dev_we;
   logic [31:0] dev_addr, dev_wdata;
   logic [3:0]  dev_be;
   logic        dev_rvalid, dev_err;
   logic [31:0] dev_rdata;
   logic        host_req, host_gnt, host_rvalid, host_err;
   logic [31:0] host_addr, host_rdata;
   logic        sig_valid, sig_ready;
   logic [31:0] sig_data;
   logic        done;
   logic [31:0] exit_code;

   typedef struct {
      logic [31:0] addr;
      int unsigned due;
   } rsp_t;

   rsp_t        pend[$];
   logic [31:0] got_q[$];
   logic [31:0] exp_q[$];
   int unsigned cyc, gnt_delay, rv_min, rv_max, gnt_wait, last_due;
   int unsigned resp_count, err_at, gnt_count, max_ost, addr_viol;
   bit          ready_en, ready_rand, prev_wait;
   logic [31:0] prev_addr;
   int          checks, failures;

   testutil_sigdump #(
      .AddrWidth      (32),
      .DataWidth      (32),
      .MaxOutstanding (2),
      .SigFifoDepth   (4)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .dev_req_i     (dev_req),
      .dev_we_i      (dev_we),
      .dev_addr_i    (dev_addr),
      .dev_wdata_i   (dev_wdata),
      .dev_be_i      (dev_be),
      .dev_rvalid_o  (dev_rvalid),
      .dev_rdata_o   (dev_rdata),
      .dev_err_o     (dev_err),
      .host_req_o    (host_req),
      .host_gnt_i    (host_gnt),
      .host_addr_o   (host_addr),
      .host_rvalid_i (host_rvalid),
      .host_rdata_i  (host_rdata),
      .host_err_i    (host_err),
      .sig_valid_o   (sig_valid),
      .sig_ready_i   (sig_ready),
      .sig_data_o    (sig_data),
      .done_o        (done),
      .exit_code_o   (exit_code)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Host memory model and dumper, driven on the falling edge.
   initial begin
      rsp_t        r;
      int unsigned due;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            pend.delete();
            host_gnt = 0; host_rvalid = 0; host_err = 0; host_rdata = '0;
            gnt_wait = 0; prev_wait = 0; sig_ready = 0;
            continue;
         end
         if (pend.size() > max_ost) max_ost = pend.size();
         if (prev_wait && (!host_req || host_addr !== prev_addr)) addr_viol++;
         if (pend.size() != 0 && pend[0].due <= cyc) begin
            r = pend.pop_front();
            host_rvalid = 1; host_rdata = r.addr; host_err = (resp_count == err_at);
            resp_count++;
         end else begin
            host_rvalid = 0; host_rdata = '0; host_err = 0;
         end
         host_gnt = 0;
         if (host_req) begin
            if (gnt_wait >= gnt_delay) begin
               host_gnt = 1;
               gnt_wait = 0;
               due = cyc + $urandom_range(rv_max, rv_min);
               if (due <= last_due) due = last_due + 1;
               last_due = due;
               pend.push_back('{host_addr, due});
               gnt_count++;
            end else begin
               gnt_wait++;
            end
         end
         prev_wait = host_req && !host_gnt;
         prev_addr = host_addr;
         sig_ready = ready_rand ? 1'($urandom_range(1, 0)) : ready_en;
         if (sig_valid && sig_ready) got_q.push_back(sig_data);
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic do_reset;
      rst_n = 0; ready_en = 0; ready_rand = 0;
      dev_req = 0; dev_we = 0; dev_addr = '0; dev_wdata = '0; dev_be = '0;
      gnt_delay = 0; rv_min = 1; rv_max = 1; err_at = 32'hFFFF_FFFF;
      repeat (3) @(posedge clk);
      @(negedge clk); #2;
      rst_n = 1;
      got_q.delete(); exp_q.delete();
      gnt_count = 0; resp_count = 0; max_ost = 0; addr_viol = 0; last_due = 0;
   endtask

   task automatic dev_access(input logic we, input logic [7:0] off, input logic [31:0] wd,
                             input logic [3:0] be, output logic rv, output logic [31:0] rd,
                             output logic er);
      @(posedge clk); #1;
      dev_req = 1; dev_we = we; dev_addr = {24'hA5_0000, off}; dev_wdata = wd; dev_be = be;
      @(posedge clk); #1;
      dev_req = 0; dev_we = 0; dev_wdata = '0; dev_be = '0;
      rv = dev_rvalid; rd = dev_rdata; er = dev_err;
   endtask

   task automatic push_range(input longint unsigned b, input longint unsigned e);
      for (longint unsigned a = b & ~64'd3; a < e; a += 4) exp_q.push_back(32'(a));
   endtask

   task automatic wait_done(input int unsigned budget, output bit ok);
      ok = 0;
      for (int unsigned i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (done) begin ok = 1; break; end
      end
   endtask

   task automatic test_reset;
      logic rv, er; logic [31:0] rd;
      do_reset();
      #1;
      checks++; if ({host_req, sig_valid, done, dev_rvalid, dev_err} !== 5'b0) begin
         failures++; $display("FAIL reset_flags got=%b exp=00000", {host_req, sig_valid, done, dev_rvalid, dev_err}); end
      checks++; if (exit_code !== 32'h0 || sig_data !== 32'h0 || host_addr !== 32'h0 || dev_rdata !== 32'h0) begin
         failures++; $display("FAIL reset_data exit=%h sig=%h addr=%h rdata=%h exp=0", exit_code, sig_data, host_addr, dev_rdata); end
      dev_access(0, 8'h0C, 0, 4'h0, rv, rd, er);
      checks++; if ({rv, er, rd} !== {1'b1, 1'b0, 32'h0}) begin
         failures++; $display("FAIL reset_status rv=%b err=%b got=%h exp=00000000", rv, er, rd); end
      dev_access(0, 8'h00, 0, 4'h0, rv, rd, er);
      checks++; if (rd !== 32'h0 || er !== 1'b0) begin
         failures++; $display("FAIL reset_sig_begin got=%h err=%b exp=0", rd, er); end
      dev_access(0, 8'h14, 0, 4'h0, rv, rd, er);
      checks++; if ({rv, er, rd} !== {1'b1, 1'b1, 32'h0}) begin
         failures++; $display("FAIL unmapped_14 rv=%b err=%b rd=%h exp=1 1 0", rv, er, rd); end
      dev_access(1, 8'h10, 32'h41, 4'hF, rv, rd, er);
      checks++; if (er !== 1'b1) begin
         failures++; $display("FAIL console_unmapped err=%b exp=1", er); end
   endtask

   task automatic test_basic;
      logic rv, er; logic [31:0] rd, e, g; bit ok;
      do_reset();
      ready_en = 1;
      dev_access(1, 8'h00, 32'h100, 4'hF, rv, rd, er);
      dev_access(1, 8'h04, 32'h110, 4'hF, rv, rd, er);
      dev_access(0, 8'h04, 0, 4'h0, rv, rd, er);
      checks++; if (rd !== 32'h110 || er !== 1'b0) begin
         failures++; $display("FAIL basic_end_readback got=%h exp=00000110", rd); end
      push_range(64'h100, 64'h110);
      dev_access(1, 8'h08, 32'h0, 4'hF, rv, rd, er);
      checks++; if ({rv, er, rd} !== {1'b1, 1'b0, 32'h0}) begin
         failures++; $display("FAIL basic_exit_rsp rv=%b err=%b rd=%h exp=1 0 0", rv, er, rd); end
      wait_done(200, ok);
      checks++; if (!ok) begin failures++; $display("FAIL basic_done timeout got=0 exp=1"); end
      checks++; if (got_q.size() != exp_q.size()) begin
         failures++; $display("FAIL basic_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); g = (got_q.size() != 0) ? got_q.pop_front() : 32'hxxxx_xxxx;
         checks++; if (g !== e) begin failures++; $display("FAIL basic_word got=%h exp=%h", g, e); end
      end
      checks++; if (exit_code !== 32'h0) begin failures++; $display("FAIL basic_exit_code got=%h exp=0", exit_code); end
      dev_access(0, 8'h0C, 0, 4'h0, rv, rd, er);
      checks++; if (rd !== 32'h2) begin failures++; $display("FAIL basic_status got=%h exp=00000002", rd); end
   endtask

   task automatic test_empty_range;
      logic rv, er; logic [31:0] rd;
      do_reset();
      ready_en = 1;
      dev_access(1, 8'h00, 32'h1122_3344, 4'hF, rv, rd, er);
      dev_access(1, 8'h00, 32'hAABB_CCDD, 4'h3, rv, rd, er);
      dev_access(0, 8'h00, 0, 4'h0, rv, rd, er);
      checks++; if (rd !== 32'h1122_CCDD) begin failures++; $display("FAIL partial_write got=%h exp=1122ccdd", rd); end
      dev_access(1, 8'h00, 32'h200, 4'hF, rv, rd, er);
      dev_access(1, 8'h04, 32'h200, 4'hF, rv, rd, er);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL empty_pre_done got=%b exp=0", done); end
      dev_access(1, 8'h08, 32'h7, 4'hF, rv, rd, er);
      checks++; if (done !== 1'b1 || exit_code !== 32'h7) begin
         failures++; $display("FAIL empty_done done=%b exit=%h exp=1 00000007", done, exit_code); end
      repeat (8) @(posedge clk);
      #1;
      checks++; if (gnt_count != 0 || got_q.size() != 0 || sig_valid !== 1'b0) begin
         failures++; $display("FAIL empty_no_words grants=%0d words=%0d valid=%b exp=0 0 0", gnt_count, got_q.size(), sig_valid); end
   endtask

   task automatic test_stall;
      logic rv, er; logic [31:0] rd, e, g; bit ok;
      do_reset();
      dev_access(1, 8'h00, 32'h1000, 4'hF, rv, rd, er);
      dev_access(1, 8'h04, 32'h1020, 4'hF, rv, rd, er);
      push_range(64'h1000, 64'h1020);
      dev_access(1, 8'h08, 32'h1, 4'hF, rv, rd, er);
      repeat (20) @(posedge clk);
      #1;
      checks++; if (gnt_count != 4 || host_req !== 1'b0 || sig_valid !== 1'b1 || got_q.size() != 0) begin
         failures++; $display("FAIL stall_hold grants=%0d req=%b valid=%b words=%0d exp=4 0 1 0", gnt_count, host_req, sig_valid, got_q.size()); end
      ready_en = 1;
      wait_done(300, ok);
      checks++; if (!ok) begin failures++; $display("FAIL stall_done timeout got=0 exp=1"); end
      checks++; if (got_q.size() != exp_q.size()) begin
         failures++; $display("FAIL stall_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); g = (got_q.size() != 0) ? got_q.pop_front() : 32'hxxxx_xxxx;
         checks++; if (g !== e) begin failures++; $display("FAIL stall_word got=%h exp=%h", g, e); end
      end
   endtask

   task automatic test_slow_host;
      logic rv, er; logic [31:0] rd, e, g; bit ok;
      do_reset();
      gnt_delay = 3; rv_min = 1; rv_max = 5; ready_rand = 1;
      dev_access(1, 8'h00, 32'h2000, 4'hF, rv, rd, er);
      dev_access(1, 8'h04, 32'h2020, 4'hF, rv, rd, er);
      push_range(64'h2000, 64'h2020);
      dev_access(1, 8'h08, 32'h2, 4'hF, rv, rd, er);
      wait_done(1000, ok);
      checks++; if (!ok) begin failures++; $display("FAIL slow_done timeout got=0 exp=1"); end
      checks++; if (addr_viol != 0) begin failures++; $display("FAIL slow_addr_stable violations=%0d exp=0", addr_viol); end
      checks++; if (max_ost > 2) begin failures++; $display("FAIL slow_outstanding got=%0d exp<=2", max_ost); end
      checks++; if (got_q.size() != exp_q.size()) begin
         failures++; $display("FAIL slow_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); g = (got_q.size() != 0) ? got_q.pop_front() : 32'hxxxx_xxxx;
         checks++; if (g !== e) begin failures++; $display("FAIL slow_word got=%h exp=%h", g, e); end
      end
   endtask

   task automatic test_host_err;
      logic rv, er; logic [31:0] rd, e, g; bit ok;
      do_reset();
      err_at = 1;
      dev_access(1, 8'h00, 32'h300, 4'hF, rv, rd, er);
      dev_access(1, 8'h04, 32'h310, 4'hF, rv, rd, er);
      push_range(64'h300, 64'h310);
      dev_access(1, 8'h08, 32'h3, 4'hF, rv, rd, er);
      dev_access(1, 8'h00, 32'h999, 4'hF, rv, rd, er);
      checks++; if ({rv, er} !== 2'b11) begin failures++; $display("FAIL busy_write_err rv=%b err=%b exp=1 1", rv, er); end
      repeat (10) @(posedge clk);
      dev_access(0, 8'h0C, 0, 4'h0, rv, rd, er);
      checks++; if (rd !== 32'h5) begin failures++; $display("FAIL err_status_busy got=%h exp=00000005", rd); end
      dev_access(0, 8'h00, 0, 4'h0, rv, rd, er);
      checks++; if (rd !== 32'h300) begin failures++; $display("FAIL busy_write_ignored got=%h exp=00000300", rd); end
      ready_en = 1;
      wait_done(200, ok);
      checks++; if (!ok) begin failures++; $display("FAIL err_done timeout got=0 exp=1"); end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); g = (got_q.size() != 0) ? got_q.pop_front() : 32'hxxxx_xxxx;
         checks++; if (g !== e) begin failures++; $display("FAIL err_word got=%h exp=%h", g, e); end
      end
      dev_access(0, 8'h0C, 0, 4'h0, rv, rd, er);
      checks++; if (rd !== 32'h6) begin failures++; $display("FAIL err_status_done got=%h exp=00000006", rd); end
   endtask

   task automatic test_wrap;
      logic rv, er; logic [31:0] rd, e, g; bit ok;
      do_reset();
      ready_en = 1;
      dev_access(1, 8'h00, 32'hFFFF_FFF8, 4'hF, rv, rd, er);
      dev_access(1, 8'h04, 32'hFFFF_FFFF, 4'hF, rv, rd, er);
      push_range(64'hFFFF_FFF8, 64'hFFFF_FFFF);
      dev_access(1, 8'h08, 32'h4, 4'hF, rv, rd, er);
      wait_done(200, ok);
      checks++; if (!ok || gnt_count != 2) begin
         failures++; $display("FAIL wrap_stop done=%b grants=%0d exp=1 2", ok, gnt_count); end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); g = (got_q.size() != 0) ? got_q.pop_front() : 32'hxxxx_xxxx;
         checks++; if (g !== e) begin failures++; $display("FAIL wrap_word got=%h exp=%h", g, e); end
      end
   endtask

   task automatic test_reset_mid_drain;
      logic rv, er; logic [31:0] rd, e, g; bit ok;
      int unsigned n;
      do_reset();
      dev_access(1, 8'h00, 32'h400, 4'hF, rv, rd, er);
      dev_access(1, 8'h04, 32'h410, 4'hF, rv, rd, er);
      dev_access(1, 8'h08, 32'h5, 4'hF, rv, rd, er);
      n = 0;
      while (gnt_count < 4 && n < 100) begin @(posedge clk); n++; end
      repeat (6) @(posedge clk);
      dev_access(0, 8'h0C, 0, 4'h0, rv, rd, er);
      checks++; if (rd !== 32'h1 || host_req !== 1'b0) begin
         failures++; $display("FAIL drain_status got=%h req=%b exp=00000001 0", rd, host_req); end
      @(posedge clk); #1;
      rst_n = 0;
      #1;
      checks++; if ({host_req, sig_valid, done, dev_rvalid} !== 4'b0 || exit_code !== 32'h0 || sig_data !== 32'h0) begin
         failures++; $display("FAIL async_reset flags=%b exit=%h sig=%h exp=0", {host_req, sig_valid, done, dev_rvalid}, exit_code, sig_data); end
      do_reset();
      ready_en = 1;
      dev_access(1, 8'h00, 32'h500, 4'hF, rv, rd, er);
      dev_access(1, 8'h04, 32'h508, 4'hF, rv, rd, er);
      push_range(64'h500, 64'h508);
      dev_access(1, 8'h08, 32'h9, 4'hF, rv, rd, er);
      wait_done(200, ok);
      checks++; if (!ok || exit_code !== 32'h9) begin
         failures++; $display("FAIL redump_done done=%b exit=%h exp=1 00000009", ok, exit_code); end
      checks++; if (got_q.size() != exp_q.size()) begin
         failures++; $display("FAIL redump_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); g = (got_q.size() != 0) ? got_q.pop_front() : 32'hxxxx_xxxx;
         checks++; if (g !== e) begin failures++; $display("FAIL redump_word got=%h exp=%h", g, e); end
      end
   endtask

   initial begin
      checks = 0; failures = 0; cyc = 0;
      rst_n = 0; host_gnt = 0; host_rvalid = 0; host_err = 0; host_rdata = '0; sig_ready = 0;
      dev_req = 0; dev_we = 0; dev_addr = '0; dev_wdata = '0; dev_be = '0;
      test_reset();
      test_basic();
      test_empty_range();
      test_stall();
      test_slow_host();
      test_host_err();
      test_wrap();
      test_reset_mid_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
